// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, runs the single-outstanding
// instruction-memory handshake, squashes responses made stale by execute
// redirects and hands instructions to decode through a one-entry buffer.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        ex_redirect_valid,
    input  logic [31:0] ex_redirect_pc,
    input  logic        stall,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state;
    logic        drop;
    logic [31:0] redirect_tgt;

    // Instruction fetches are word aligned; the low address bits of a
    // redirect target are ignored.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    assign redirect_tgt  = align_word(ex_redirect_pc);
    assign imem_req_addr = pc;

    // A request goes out only when no redirect is pending this cycle and the
    // buffer is empty or being drained, so a returning response always has room.
    always_comb begin
        imem_req_valid = 1'b0;
        if (state == REQ) begin
            imem_req_valid = !ex_redirect_valid && (!if_valid || !stall);
        end
    end

    // Sequencer: PC, outstanding/stale tracking, output buffer and counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            drop        <= 1'b0;
            if_valid    <= 1'b0;
            if_pc       <= 32'h0000_0000;
            if_instr    <= NOP_INSTR;
            fetch_count <= 32'h0000_0000;
        end else begin
            // Decode drains the buffer; a refill below takes precedence.
            if (if_valid && !stall) begin
                if_valid <= 1'b0;
            end
            case (state)
                BOOT: begin
                    if (ex_redirect_valid) begin
                        pc       <= redirect_tgt;
                        if_valid <= 1'b0;
                        if_instr <= NOP_INSTR;
                    end
                    state <= REQ;
                end
                REQ: begin
                    if (ex_redirect_valid) begin
                        pc       <= redirect_tgt;
                        if_valid <= 1'b0;
                        if_instr <= NOP_INSTR;
                    end else if (imem_req_valid && imem_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        // The one outstanding response has returned, so
                        // nothing stale can remain in flight.
                        state <= REQ;
                        drop  <= 1'b0;
                        if (ex_redirect_valid) begin
                            pc       <= redirect_tgt;
                            if_valid <= 1'b0;
                            if_instr <= NOP_INSTR;
                        end else if (!drop) begin
                            if_instr    <= imem_rsp_data;
                            if_pc       <= pc;
                            if_valid    <= 1'b1;
                            pc          <= next_pc;
                            fetch_count <= fetch_count + 32'd1;
                        end
                    end else if (ex_redirect_valid) begin
                        // Response still in flight belongs to the old path.
                        pc       <= redirect_tgt;
                        drop     <= 1'b1;
                        if_valid <= 1'b0;
                        if_instr <= NOP_INSTR;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: hand-computed vector table, directed corner
// sequences, then randomized traffic against a transaction-level model.
module tb_fetch_pc_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] next_pc;
    logic        ex_redirect_valid;
    logic [31:0] ex_redirect_pc;
    logic        stall;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    fetch_pc_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .next_pc           (next_pc),
        .ex_redirect_valid (ex_redirect_valid),
        .ex_redirect_pc    (ex_redirect_pc),
        .stall             (stall),
        .imem_req_valid    (imem_req_valid),
        .imem_req_addr     (imem_req_addr),
        .imem_req_ready    (imem_req_ready),
        .imem_rsp_valid    (imem_rsp_valid),
        .imem_rsp_data     (imem_rsp_data),
        .pc                (pc),
        .if_valid          (if_valid),
        .if_pc             (if_pc),
        .if_instr          (if_instr),
        .fetch_count       (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        st;
        logic        rdy;
        logic        sv;
        logic [31:0] sd;
        logic [31:0] np;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_ifv;
        logic [31:0] e_ifpc;
        logic [31:0] e_instr;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(logic rv, logic [31:0] rpc, logic st, logic rdy,
                                logic sv, logic [31:0] sd, logic [31:0] np,
                                logic e_req, logic [31:0] e_addr, logic e_ifv,
                                logic [31:0] e_ifpc, logic [31:0] e_instr,
                                logic [31:0] e_cnt);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.st = st; v.rdy = rdy; v.sv = sv; v.sd = sd;
        v.np = np; v.e_req = e_req; v.e_addr = e_addr; v.e_ifv = e_ifv;
        v.e_ifpc = e_ifpc; v.e_instr = e_instr; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic check_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                             input logic e_ifv, input logic [31:0] e_ifpc,
                             input logic [31:0] e_instr, input logic [31:0] e_cnt);
        chk({tag, "_req_valid"}, {31'd0, imem_req_valid}, {31'd0, e_req});
        chk({tag, "_req_addr"}, imem_req_addr, e_addr);
        chk({tag, "_pc"}, pc, e_addr);
        chk({tag, "_if_valid"}, {31'd0, if_valid}, {31'd0, e_ifv});
        chk({tag, "_if_pc"}, if_pc, e_ifpc);
        chk({tag, "_if_instr"}, if_instr, e_instr);
        chk({tag, "_fetch_count"}, fetch_count, e_cnt);
    endtask

    task automatic drive(input logic rv, input logic [31:0] rpc, input logic st,
                         input logic rdy, input logic sv, input logic [31:0] sd,
                         input logic [31:0] np);
        ex_redirect_valid = rv;
        ex_redirect_pc    = rpc;
        stall             = st;
        imem_req_ready    = rdy;
        imem_rsp_valid    = sv;
        imem_rsp_data     = sd;
        next_pc           = np;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- transaction-level reference model ----------------
    // m_out: responses the memory still owes; m_stale: how many of those
    // belong to a path abandoned by a redirect.
    bit          m_boot;
    int          m_out;
    int          m_stale;
    logic [31:0] m_pc;
    bit          m_bv;
    logic [31:0] m_bpc;
    logic [31:0] m_binstr;
    logic [31:0] m_cnt;

    function automatic bit m_req_exp();
        return !m_boot && (m_out == 0) && !ex_redirect_valid && (!m_bv || !stall);
    endfunction

    task automatic model_reset();
        m_boot = 1; m_out = 0; m_stale = 0; m_pc = 32'h0;
        m_bv = 0; m_bpc = 32'h0; m_binstr = NOP; m_cnt = 32'h0;
    endtask

    task automatic model_redirect();
        m_pc     = ex_redirect_pc & ~32'h3;
        m_bv     = 0;
        m_binstr = NOP;
    endtask

    task automatic model_step();
        bit issue;
        issue = m_req_exp() && imem_req_ready;
        if (m_bv && !stall) m_bv = 0;
        if (m_boot) begin
            m_boot = 0;
            if (ex_redirect_valid) model_redirect();
        end else if (m_out == 0) begin
            if (ex_redirect_valid) model_redirect();
            else if (issue) m_out = 1;
        end else if (imem_rsp_valid) begin
            m_out = m_out - 1;
            if (ex_redirect_valid) begin
                model_redirect();
                m_stale = 0;
            end else if (m_stale > 0) begin
                m_stale = m_stale - 1;
            end else begin
                m_bv     = 1;
                m_bpc    = m_pc;
                m_binstr = imem_rsp_data;
                m_pc     = next_pc;
                m_cnt    = m_cnt + 32'd1;
            end
        end else if (ex_redirect_valid) begin
            model_redirect();
            m_stale = m_out;
        end
    endtask

    initial begin
        int          cyc;
        bit          mem_busy;
        int          mem_due;
        logic [31:0] mem_data;
        logic [31:0] r;

        tbl[0]  = mk(0, 32'h0,   0, 1, 0, 32'h0,    32'h0,   0, 32'h0,   0, 32'h0,   NOP,      0);
        tbl[1]  = mk(0, 32'h0,   0, 1, 0, 32'h0,    32'h0,   1, 32'h0,   0, 32'h0,   NOP,      0);
        tbl[2]  = mk(0, 32'h0,   0, 1, 1, 32'hA0,   32'h4,   0, 32'h0,   0, 32'h0,   NOP,      0);
        tbl[3]  = mk(0, 32'h0,   0, 1, 0, 32'h0,    32'h0,   1, 32'h4,   1, 32'h0,   32'hA0,   1);
        tbl[4]  = mk(0, 32'h0,   0, 1, 1, 32'hA1,   32'h8,   0, 32'h4,   0, 32'h0,   32'hA0,   1);
        tbl[5]  = mk(0, 32'h0,   0, 1, 0, 32'h0,    32'h0,   1, 32'h8,   1, 32'h4,   32'hA1,   2);
        tbl[6]  = mk(0, 32'h0,   0, 1, 1, 32'hA2,   32'hC,   0, 32'h8,   0, 32'h4,   32'hA1,   2);
        tbl[7]  = mk(0, 32'h0,   1, 1, 0, 32'h0,    32'h0,   0, 32'hC,   1, 32'h8,   32'hA2,   3);
        tbl[8]  = mk(0, 32'h0,   1, 1, 0, 32'h0,    32'h0,   0, 32'hC,   1, 32'h8,   32'hA2,   3);
        tbl[9]  = mk(0, 32'h0,   0, 1, 0, 32'h0,    32'h0,   1, 32'hC,   1, 32'h8,   32'hA2,   3);
        tbl[10] = mk(0, 32'h0,   0, 1, 1, 32'hA3,   32'h10,  0, 32'hC,   0, 32'h8,   32'hA2,   3);
        tbl[11] = mk(0, 32'h0,   0, 1, 0, 32'h0,    32'h0,   1, 32'h10,  1, 32'hC,   32'hA3,   4);
        tbl[12] = mk(1, 32'h103, 0, 1, 0, 32'h0,    32'h0,   0, 32'h10,  0, 32'hC,   32'hA3,   4);
        tbl[13] = mk(0, 32'h0,   0, 1, 0, 32'h0,    32'h0,   0, 32'h100, 0, 32'hC,   NOP,      4);
        tbl[14] = mk(0, 32'h0,   0, 1, 1, 32'hDEAD, 32'h500, 0, 32'h100, 0, 32'hC,   NOP,      4);
        tbl[15] = mk(0, 32'h0,   0, 1, 0, 32'h0,    32'h0,   1, 32'h100, 0, 32'hC,   NOP,      4);
        tbl[16] = mk(1, 32'h200, 0, 1, 1, 32'hBEEF, 32'h600, 0, 32'h100, 0, 32'hC,   NOP,      4);
        tbl[17] = mk(0, 32'h0,   0, 1, 0, 32'h0,    32'h0,   1, 32'h200, 0, 32'hC,   NOP,      4);
        tbl[18] = mk(0, 32'h0,   0, 1, 1, 32'hB0,   32'h204, 0, 32'h200, 0, 32'hC,   NOP,      4);
        tbl[19] = mk(0, 32'h0,   1, 1, 0, 32'h0,    32'h0,   0, 32'h204, 1, 32'h200, 32'hB0,   5);
        tbl[20] = mk(1, 32'h301, 1, 1, 0, 32'h0,    32'h0,   0, 32'h204, 1, 32'h200, 32'hB0,   5);
        tbl[21] = mk(0, 32'h0,   0, 0, 0, 32'h0,    32'h0,   1, 32'h300, 0, 32'h200, NOP,      5);

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_all("reset", 0, 32'h0, 0, 32'h0, NOP, 0);
        next_cycle();
        rst = 1'b0;

        // Vector table: boot, sequential fetch, stall, redirects.
        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].rv, tbl[i].rpc, tbl[i].st, tbl[i].rdy, tbl[i].sv, tbl[i].sd, tbl[i].np);
            @(negedge clk);
            check_all($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_ifv,
                      tbl[i].e_ifpc, tbl[i].e_instr, tbl[i].e_cnt);
            next_cycle();
        end

        // Memory wait states: address held while not ready.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            check_all($sformatf("ws_hold%0d", i), 1, 32'h300, 0, 32'h200, NOP, 5);
            next_cycle();
        end
        drive(0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        check_all("ws_accept", 1, 32'h300, 0, 32'h200, NOP, 5);
        next_cycle();
        drive(0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        check_all("ws_wait", 0, 32'h300, 0, 32'h200, NOP, 5);
        next_cycle();
        drive(0, 0, 0, 1, 1, 32'hC0, 32'h304);
        @(negedge clk);
        check_all("ws_rsp", 0, 32'h300, 0, 32'h200, NOP, 5);
        next_cycle();
        drive(0, 0, 1, 1, 0, 0, 0);
        @(negedge clk);
        check_all("ws_deliver", 0, 32'h304, 1, 32'h300, 32'hC0, 6);
        next_cycle();
        // Unsolicited response in REQ is ignored.
        drive(0, 0, 1, 1, 1, 32'hBAD, 32'h900);
        @(negedge clk);
        check_all("spurious_req", 0, 32'h304, 1, 32'h300, 32'hC0, 6);
        next_cycle();
        drive(0, 0, 1, 1, 0, 0, 0);
        @(negedge clk);
        check_all("spurious_after", 0, 32'h304, 1, 32'h300, 32'hC0, 6);
        next_cycle();
        drive(0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        check_all("stall_release", 1, 32'h304, 1, 32'h300, 32'hC0, 6);
        next_cycle();

        // Asynchronous reset while waiting for a response.
        drive(0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        check_all("pre_areset", 0, 32'h304, 0, 32'h300, 32'hC0, 6);
        #2;
        rst = 1'b1;
        #1;
        check_all("areset", 0, 32'h0, 0, 32'h0, NOP, 0);
        next_cycle();
        rst = 1'b0;
        drive(0, 0, 0, 1, 1, 32'hDD, 32'h700);
        @(negedge clk);
        check_all("late_rsp_boot", 0, 32'h0, 0, 32'h0, NOP, 0);
        next_cycle();
        drive(0, 0, 0, 0, 1, 32'hDD, 32'h700);
        @(negedge clk);
        check_all("late_rsp_req", 1, 32'h0, 0, 32'h0, NOP, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_all("late_rsp_after", 1, 32'h0, 0, 32'h0, NOP, 0);
        next_cycle();

        // Randomized traffic against the reference model.
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        mem_busy = 0;
        mem_due  = 0;
        mem_data = 32'h0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        for (cyc = 0; cyc < 3000; cyc++) begin
            r = $urandom;
            ex_redirect_valid = ($urandom_range(0, 9) == 0);
            ex_redirect_pc    = r;
            stall             = ($urandom_range(0, 2) == 0);
            imem_req_ready    = ($urandom_range(0, 2) != 0);
            r = $urandom;
            next_pc = ($urandom_range(0, 3) == 0) ? (r & ~32'h3) : (pc + 32'd4);
            if (mem_busy && cyc == mem_due) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_data;
            end else if (!mem_busy && $urandom_range(0, 15) == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = $urandom;
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
            end
            @(negedge clk);
            check_all($sformatf("rnd%0d", cyc), m_req_exp(), m_pc, m_bv, m_bpc, m_binstr, m_cnt);
            if (mem_busy && cyc == mem_due) mem_busy = 0;
            if (imem_req_valid && imem_req_ready) begin
                mem_busy = 1;
                mem_due  = cyc + $urandom_range(1, 4);
                mem_data = $urandom;
            end
            model_step();
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
